// File: rtl/x_req_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : x_req_ctrl_if
//  Description : Bundle of the arbiter handshake (request vector, enable,
//                grant, group release) and the downstream event stream
//                (valid/ready with lane address and group tag) used by
//                x_req_ctrl.
//  Modports    : master - the request controller (drives req/en/event data)
//                slave  - the arbiter plus downstream consumer side
//  Signals     : arb_req_o[3:0], arb_en_o, arb_gnt_i[3:0], arb_grp_rel_i,
//                ev_valid_o, ev_ready_i, ev_addr_o[1:0], ev_grp_o[GRP_W-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface x_req_ctrl_if #(
  parameter int GRP_W = 4
);
  logic [3:0]       arb_req_o;
  logic             arb_en_o;
  logic [3:0]       arb_gnt_i;
  logic             arb_grp_rel_i;
  logic             ev_valid_o;
  logic             ev_ready_i;
  logic [1:0]       ev_addr_o;
  logic [GRP_W-1:0] ev_grp_o;

  modport master (
    output arb_req_o, arb_en_o, ev_valid_o, ev_addr_o, ev_grp_o,
    input  arb_gnt_i, arb_grp_rel_i, ev_ready_i
  );

  modport slave (
    input  arb_req_o, arb_en_o, ev_valid_o, ev_addr_o, ev_grp_o,
    output arb_gnt_i, arb_grp_rel_i, ev_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/x_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : x_req_ctrl
//  Description : Requester-side companion to the 4-lane X round-robin
//                arbiter. Latches per-lane event pulses into a pending
//                register presented as arbiter requests, pulses the arbiter
//                enable in a two-phase ARB/GNT handshake so each grant is
//                consumed once, and queues {lane, group tag} results in a
//                first-word fall-through FIFO towards the next stage.
//  Ports       : clk, reset      - clock, asynchronous active-high reset
//                ev_i[3:0]       - per-lane single-cycle event pulses
//                bus (master)    - arbiter handshake + downstream stream
//                drop_cnt_o      - saturating count of dropped events
//                gnt_err_o       - sticky flag: zero / multi-hot grant seen
//                busy_o          - pending, handshake or FIFO activity
//  Revision    : 1.0 - initial release
// ============================================================================
module x_req_ctrl #(
  parameter int DEPTH  = 4,
  parameter int GRP_W  = 4,
  parameter int DROP_W = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic [3:0]        ev_i,
  x_req_ctrl_if.master           bus,
  output logic [DROP_W-1:0]      drop_cnt_o,
  output logic                   gnt_err_o,
  output logic                   busy_o
);

  localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam int                 c_ENT_W = 2 + GRP_W;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_GNT  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_arb_en;
  logic [3:0]          r_pending;
  logic [GRP_W-1:0]    r_grp_cnt;
  logic [DROP_W-1:0]   r_drop_cnt;
  logic                r_gnt_err;

  logic [c_ENT_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_cnt;

  logic [3:0]          w_gnt;
  logic                w_gnt_onehot;
  logic                w_push;
  logic                w_pop;
  logic [3:0]          w_clear;
  logic [1:0]          w_lane;
  logic [3:0]          w_pend_cleared;
  logic [3:0]          w_pend_next;
  logic [3:0]          w_drop_vec;
  logic [2:0]          w_drop_n;
  logic [DROP_W:0]     w_drop_sum;
  logic [DROP_W-1:0]   w_drop_next;
  logic [c_CNT_W-1:0]  w_cnt_next;
  logic                w_valid;
  logic [c_ENT_W-1:0]  w_head;

  // --------------------------------------------------------------------------
  // Grant qualification: only a one-hot grant sampled in GNT is consumed.
  // --------------------------------------------------------------------------
  assign w_gnt        = bus.arb_gnt_i;
  assign w_gnt_onehot = (w_gnt != 4'd0) && ((w_gnt & (w_gnt - 4'd1)) == 4'd0);
  assign w_push       = (r_state == S_GNT) && w_gnt_onehot;
  assign w_clear      = w_push ? w_gnt : 4'd0;

  always_comb begin
    w_lane = 2'd0;
    case (w_gnt)
      4'b0001: w_lane = 2'd0;
      4'b0010: w_lane = 2'd1;
      4'b0100: w_lane = 2'd2;
      4'b1000: w_lane = 2'd3;
      default: w_lane = 2'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pending / drop bookkeeping. A new event on a lane being cleared this cycle
  // re-arms it rather than counting as a drop, hence the drop test against
  // the already-cleared vector.
  // --------------------------------------------------------------------------
  assign w_pend_cleared = r_pending & ~w_clear;
  assign w_pend_next    = w_pend_cleared | ev_i;
  assign w_drop_vec     = ev_i & w_pend_cleared;
  assign w_drop_n       = {2'b00, w_drop_vec[0]} + {2'b00, w_drop_vec[1]}
                        + {2'b00, w_drop_vec[2]} + {2'b00, w_drop_vec[3]};
  assign w_drop_sum     = {1'b0, r_drop_cnt} + (DROP_W+1)'(w_drop_n);
  assign w_drop_next    = w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending  <= 4'd0;
      r_drop_cnt <= '0;
    end else begin
      r_pending  <= w_pend_next;
      r_drop_cnt <= w_drop_next;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO occupancy. The handshake launch conditions guarantee no overflow.
  // --------------------------------------------------------------------------
  assign w_valid    = (r_cnt != '0);
  assign w_pop      = w_valid && bus.ev_ready_i;
  assign w_cnt_next = r_cnt + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_cnt <= w_cnt_next;
    end
  end

  // Storage needs no reset: contents are only exposed while the entry count
  // says they were written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_lane, r_grp_cnt};
  end

  // --------------------------------------------------------------------------
  // Handshake FSM: IDLE -> ARB (enable pulse) -> GNT (consume grant).
  // The group counter advances during ARB so the GNT push already carries
  // the tag of the new round.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_arb_en  <= 1'b0;
      r_grp_cnt <= '0;
      r_gnt_err <= 1'b0;
    end else begin
      r_arb_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if ((r_pending != 4'd0) && (r_cnt < c_DEPTH)) begin
            r_state  <= S_ARB;
            r_arb_en <= 1'b1;
          end
        end
        S_ARB: begin
          if (bus.arb_grp_rel_i) r_grp_cnt <= r_grp_cnt + GRP_W'(1);
          r_state <= S_GNT;
        end
        S_GNT: begin
          if (!w_gnt_onehot) r_gnt_err <= 1'b1;
          // Back-to-back launch only on requests that existed before this
          // cycle; freshly arriving events are picked up via IDLE.
          if ((w_pend_cleared != 4'd0) && (w_cnt_next < c_DEPTH)) begin
            r_state  <= S_ARB;
            r_arb_en <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Head fields are forced to zero while the FIFO is empty.
  // --------------------------------------------------------------------------
  assign w_head         = r_mem[r_rd_ptr];
  assign bus.arb_req_o  = r_pending;
  assign bus.arb_en_o   = r_arb_en;
  assign bus.ev_valid_o = w_valid;
  assign bus.ev_addr_o  = w_valid ? w_head[c_ENT_W-1 -: 2] : 2'd0;
  assign bus.ev_grp_o   = w_valid ? w_head[GRP_W-1:0] : '0;
  assign drop_cnt_o     = r_drop_cnt;
  assign gnt_err_o      = r_gnt_err;
  assign busy_o         = (r_pending != 4'd0) || (r_state != S_IDLE) || w_valid;

endmodule
`default_nettype wire

// File: tb/tb_x_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_x_req_ctrl
//  Description : Self-checking bench for x_req_ctrl. A behavioural arbiter
//                answers each enable pulse; a transaction-level model
//                (pending set, drop count, expected output queue) predicts
//                every DUT output each cycle. Directed steps cover the
//                single-event latency, bursts, backpressure, drops,
//                same-cycle set/clear, grant errors and mid-handshake reset,
//                followed by a randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_x_req_ctrl;
  localparam int DEPTH  = 4;
  localparam int GRP_W  = 4;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        ev_i = 4'd0;
  logic [DROP_W-1:0] drop_cnt;
  logic              gnt_err;
  logic              busy;

  x_req_ctrl_if #(.GRP_W(GRP_W)) bus ();

  x_req_ctrl #(.DEPTH(DEPTH), .GRP_W(GRP_W), .DROP_W(DROP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ev_i       (ev_i),
    .bus        (bus),
    .drop_cnt_o (drop_cnt),
    .gnt_err_o  (gnt_err),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       lane;
    logic [GRP_W-1:0] grp;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model
  logic [3:0]       pend_m;
  int               drop_m;
  logic [GRP_W-1:0] grp_m;
  bit               err_m;
  ent_t             exp_q[$];
  ent_t             log_q[$];
  int               en_times[$];
  int               cyc = 0;
  bit               en_obs, en_obs_d, launch_due;

  // arbiter / stimulus controls
  int         rr;
  bit         wrap;
  int         arb_mode;   // 0 round robin, 1 zero grant, 2 random faults
  int         rel_mode;   // 0 release after lane 3, 1 random
  logic [3:0] gnt_hold;
  logic [3:0] junk_gnt;
  logic [3:0] ev_drv;
  bit         rdy_drv;
  bit         ev_on_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] lane_of(input logic [3:0] g);
    logic [1:0] l;
    l = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) l = 2'(i);
    return l;
  endfunction

  task automatic arb_pick(input logic [3:0] req, output logic [3:0] g);
    int r;
    int pick;
    g = 4'd0;
    pick = -1;
    for (int k = 0; k < 4; k++) begin
      if (pick < 0 && req[(rr + k) % 4]) pick = (rr + k) % 4;
    end
    if (pick >= 0) begin
      g = 4'(1 << pick);
      rr = (pick + 1) % 4;
      if (pick == 3) wrap = 1'b1;
    end
    if (arb_mode == 1) g = 4'd0;
    else if (arb_mode == 2) begin
      r = $urandom_range(0, 39);
      if (r == 0) g = 4'd0;
      else if (r == 1 && pick >= 0) g = g | 4'(1 << ((pick + 1) % 4));
    end
  endtask

  task automatic reset_model();
    pend_m = 4'd0; drop_m = 0; grp_m = '0; err_m = 1'b0;
    exp_q.delete();
    en_obs = 1'b0; en_obs_d = 1'b0; launch_due = 1'b0;
    rr = 0; wrap = 1'b0; gnt_hold = 4'd0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    ev_i = 4'd0; bus.arb_gnt_i = 4'd0; bus.arb_grp_rel_i = 1'b0; bus.ev_ready_i = 1'b0;
    arb_mode = 0; rel_mode = 0; junk_gnt = 4'd0; ev_drv = 4'd0; rdy_drv = 1'b0; ev_on_gnt = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then check all outputs.
  task automatic cycle();
    logic [3:0] clr, ev;
    logic       rel;
    bit         arb_ph, gnt_ph;
    int         nd;
    ent_t       e;
    arb_ph = en_obs;
    gnt_ph = en_obs_d;
    rel = 1'b0;
    if (arb_ph) begin
      if (rel_mode == 0) begin rel = wrap; wrap = 1'b0; end
      else rel = ($urandom_range(0, 3) == 0);
      arb_pick(bus.arb_req_o, gnt_hold);
    end else if (rel_mode == 1) rel = ($urandom_range(0, 3) == 0);
    if (gnt_ph)             bus.arb_gnt_i = gnt_hold;
    else if (arb_mode == 2) bus.arb_gnt_i = 4'($urandom);
    else                    bus.arb_gnt_i = junk_gnt;
    bus.arb_grp_rel_i = rel;
    ev = ev_drv;
    if (ev_on_gnt && gnt_ph) ev = ev | gnt_hold;
    ev_i = ev;
    bus.ev_ready_i = rdy_drv;

    if (bus.ev_valid_o === 1'b1 && rdy_drv) begin
      e.lane = bus.ev_addr_o; e.grp = bus.ev_grp_o;
      log_q.push_back(e);
    end
    if (exp_q.size() != 0 && rdy_drv) e = exp_q.pop_front();
    clr = 4'd0;
    if (gnt_ph) begin
      if ($countones(bus.arb_gnt_i) == 1) begin
        clr = bus.arb_gnt_i;
        e.lane = lane_of(clr); e.grp = grp_m;
        exp_q.push_back(e);
      end else err_m = 1'b1;
    end
    nd = $countones(ev & pend_m & ~clr);
    drop_m = (drop_m + nd > DROP_MAX) ? DROP_MAX : drop_m + nd;
    pend_m = (pend_m & ~clr) | ev;
    if (arb_ph && rel) grp_m = grp_m + 1'b1;

    @(posedge clk);
    #1;
    cyc++;
    en_obs_d = en_obs;
    en_obs = (bus.arb_en_o === 1'b1);
    if (en_obs) en_times.push_back(cyc);

    chk("arb_req", bus.arb_req_o, pend_m);
    chk("drop_cnt", drop_cnt, drop_m);
    chk("gnt_err", gnt_err, err_m);
    chk("ev_valid", bus.ev_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("ev_addr", bus.ev_addr_o, exp_q[0].lane);
      chk("ev_grp", bus.ev_grp_o, exp_q[0].grp);
    end else begin
      chk("ev_addr_empty", bus.ev_addr_o, 0);
      chk("ev_grp_empty", bus.ev_grp_o, 0);
    end
    if (en_obs) begin
      chk("en_back_to_back", en_obs_d, 0);
      chk("en_without_req", pend_m != 0, 1);
    end
    chk("busy", busy, (pend_m != 0) || en_obs || en_obs_d || (exp_q.size() != 0));
    if (launch_due) chk("launch", en_obs, 1);
    launch_due = !en_obs && !en_obs_d && (pend_m != 0) && (exp_q.size() < DEPTH);
  endtask

  task automatic wait_en(input int max);
    int k = 0;
    while (!en_obs && k < max) begin cycle(); k++; end
    chk("wait_en_timeout", en_obs, 1);
  endtask

  task automatic run_until_log(input int n, input int max);
    int k = 0;
    while (log_q.size() < n && k < max) begin cycle(); k++; end
    chk("log_len", log_q.size(), n);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    // ---------------- reset values + single event ----------------
    apply_reset();
    chk("rst_arb_req", bus.arb_req_o, 0);
    chk("rst_arb_en", bus.arb_en_o, 0);
    chk("rst_valid", bus.ev_valid_o, 0);
    chk("rst_addr", bus.ev_addr_o, 0);
    chk("rst_grp", bus.ev_grp_o, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_err", gnt_err, 0);
    chk("rst_busy", busy, 0);
    rdy_drv = 1'b1;
    ev_drv = 4'b0100; cycle(); ev_drv = 4'd0;
    chk("t1_en_early", bus.arb_en_o, 0);
    chk("t1_req", bus.arb_req_o, 4'b0100);
    cycle();
    chk("t1_en", bus.arb_en_o, 1);
    cycle();
    chk("t1_en_gnt", bus.arb_en_o, 0);
    cycle();
    chk("t1_valid", bus.ev_valid_o, 1);
    chk("t1_addr", bus.ev_addr_o, 2);
    chk("t1_grp", bus.ev_grp_o, 0);
    chk("t1_pend_clr", bus.arb_req_o, 0);
    cycle();
    chk("t1_popped", bus.ev_valid_o, 0);

    // ---------------- two full bursts ----------------
    apply_reset();
    rdy_drv = 1'b1;
    for (int b = 0; b < 2; b++) begin
      log_q.delete(); en_times.delete();
      ev_drv = 4'b1111; cycle(); ev_drv = 4'd0;
      run_until_log(4, 30);
      for (int i = 0; i < 4; i++) begin
        chk("burst_addr", log_q[i].lane, i);
        chk("burst_grp", log_q[i].grp, b);
      end
      chk("burst_en_n", en_times.size(), 4);
      for (int i = 1; i < 4; i++) chk("burst_en_gap", en_times[i] - en_times[i-1], 2);
      repeat (2) cycle();
    end

    // ---------------- backpressure, drops, saturation ----------------
    apply_reset();
    rdy_drv = 1'b0;
    ev_drv = 4'b1111; cycle(); ev_drv = 4'd0;
    repeat (16) cycle();
    chk("bp_valid", bus.ev_valid_o, 1);
    ev_drv = 4'b0010; cycle(); ev_drv = 4'd0;
    en_times.delete();
    repeat (6) cycle();
    chk("bp_idle_no_en", en_times.size(), 0);
    chk("bp_pending", bus.arb_req_o, 4'b0010);
    ev_drv = 4'b0010; cycle();
    chk("drop_one", drop_cnt, 1);
    repeat (300) cycle();
    chk("drop_sat", drop_cnt, DROP_MAX);
    ev_drv = 4'd0; rdy_drv = 1'b1; log_q.delete();
    run_until_log(5, 40);
    chk("bp_o0", log_q[0].lane, 0);
    chk("bp_o1", log_q[1].lane, 1);
    chk("bp_o2", log_q[2].lane, 2);
    chk("bp_o3", log_q[3].lane, 3);
    chk("bp_o4", log_q[4].lane, 1);
    chk("bp_o0_grp", log_q[0].grp, 0);
    chk("bp_o4_grp", log_q[4].grp, 1);

    // ---------------- same-cycle set and clear ----------------
    apply_reset();
    rdy_drv = 1'b1; log_q.delete();
    ev_drv = 4'b0001; cycle(); ev_drv = 4'd0;
    wait_en(5);
    ev_on_gnt = 1'b1;
    cycle();
    cycle();
    ev_on_gnt = 1'b0;
    chk("sc_pending", bus.arb_req_o, 4'b0001);
    chk("sc_no_drop", drop_cnt, 0);
    chk("sc_valid", bus.ev_valid_o, 1);
    run_until_log(2, 20);
    chk("sc_first", log_q[0].lane, 0);
    chk("sc_second", log_q[1].lane, 0);

    // ---------------- zero grant error, reset during ARB ----------------
    apply_reset();
    rdy_drv = 1'b1; arb_mode = 1;
    ev_drv = 4'b0100; cycle(); ev_drv = 4'd0;
    wait_en(5);
    cycle();
    cycle();
    chk("err_flag", gnt_err, 1);
    chk("err_pend_kept", bus.arb_req_o, 4'b0100);
    chk("err_no_push", bus.ev_valid_o, 0);
    chk("err_retry_en", bus.arb_en_o, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_en", bus.arb_en_o, 0);
    chk("ar_req", bus.arb_req_o, 0);
    chk("ar_valid", bus.ev_valid_o, 0);
    chk("ar_addr", bus.ev_addr_o, 0);
    chk("ar_grp", bus.ev_grp_o, 0);
    chk("ar_drop", drop_cnt, 0);
    chk("ar_err", gnt_err, 0);
    chk("ar_busy", busy, 0);
    reset_model();
    arb_mode = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    junk_gnt = 4'b0100;
    cycle();
    cycle();
    junk_gnt = 4'd0;
    chk("stale_req", bus.arb_req_o, 0);
    chk("stale_valid", bus.ev_valid_o, 0);
    chk("stale_err", gnt_err, 0);

    // ---------------- randomized run ----------------
    apply_reset();
    arb_mode = 2; rel_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < 4; l++) ev_drv[l] = ($urandom_range(0, 5) == 0);
      rdy_drv = ($urandom_range(0, 9) < 7);
      cycle();
    end
    ev_drv = 4'd0; rdy_drv = 1'b1; arb_mode = 0;
    k = 0;
    while (busy !== 1'b0 && k < 200) begin cycle(); k++; end
    chk("drain_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/x_req_ctrl.md
Name: x_req_ctrl

Overview:
- Requester-side companion to the 4-lane X round-robin arbiter in the EBC event path.
- Latches per-lane event pulses and presents them as arbiter requests.
- Drives the arbiter enable with a two-phase handshake so each grant is consumed exactly once.
- Encodes each grant into a lane address tagged with a group-round count, and buffers results in a small FIFO with valid/ready output towards the next stage.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, >=2)
- GRP_W, 4, width of group-round counter tag
- DROP_W, 8, width of saturating dropped-event counter

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- ev_i  in  4  per-lane event pulses (1 cycle each)
- arb_req_o  out  4  request vector to arbiter (= pending register)
- arb_en_o  out  1  arbiter enable, one-cycle pulse
- arb_gnt_i  in  4  registered one-hot grant from arbiter, valid the cycle after arb_en_o
- arb_grp_rel_i  in  1  arbiter group-release (round wrap) indication
- ev_valid_o  out  1  FIFO head valid
- ev_ready_i  in  1  downstream accept
- ev_addr_o  out  2  lane index of head entry
- ev_grp_o  out  GRP_W  group-round tag of head entry
- drop_cnt_o  out  DROP_W  saturating count of dropped events
- gnt_err_o  out  1  sticky: zero or non-one-hot grant seen
- busy_o  out  1  pending!=0 or FSM not IDLE or FIFO non-empty

Behaviour:
- Reset is asynchronous. Values on reset:
  - pending=0, FSM=IDLE, arb_en_o=0.
  - FIFO empty: ev_valid_o=0; ev_addr_o and ev_grp_o read 0.
  - grp_cnt=0, drop_cnt_o=0, gnt_err_o=0, busy_o=0.
- Pending register, per lane n:
  - Set on ev_i[n].
  - Cleared in GNT when arb_gnt_i[n]=1.
  - ev_i[n] and clear in the same cycle: pending stays 1 (new event); not a drop.
  - ev_i[n] while pending[n]=1 and no clear: event dropped; drop_cnt increments by 1 per lane dropped that cycle, saturating at all-ones.
- arb_req_o is the pending register, output directly (registered, no combinational path from ev_i).
- FSM states:
  - IDLE: go to ARB if pending!=0 and fifo_cnt<DEPTH.
  - ARB: arb_en_o=1 for exactly this cycle. If arb_grp_rel_i=1, grp_cnt<=grp_cnt+1 (wraps modulo 2^GRP_W). Always go to GNT.
  - GNT: sample arb_gnt_i.
    - If it is one-hot: clear that pending bit and push {encoded lane, grp_cnt}. Use the grp_cnt value after any increment from the preceding ARB cycle.
    - If it is zero or multi-hot: no push, no clear, set gnt_err_o (sticky until reset).
    - Next state: ARB if (pending after clear)!=0 and fifo_cnt_next<DEPTH; else IDLE.
- Each request is served in 2 cycles (ARB, GNT), so maximum throughput is one event per 2 cycles. arb_en_o is never high in two consecutive cycles.
- Lane encoding: gnt 0001->0, 0010->1, 0100->2, 1000->3.
- FIFO:
  - Synchronous, first-word fall-through.
  - Pop on ev_valid_o&ev_ready_i; push and pop in the same cycle are allowed, and fifo_cnt is unchanged.
  - Overflow is impossible because ARB is launched only when fifo_cnt_next<DEPTH. Empty pop is ignored.
- Downstream stall (ev_ready_i=0) with FIFO full: FSM holds in IDLE; pending keeps accumulating; repeat events on a lane count as drops.
- Reset asserted mid-handshake (ARB or GNT): all state cleared immediately. A grant returning after reset release is ignored because the FSM is in IDLE.

Test Plan:
- Single event: pulse ev_i=0100 with ev_ready_i=1 -> arb_en_o high 1 cycle later; arb_gnt_i=0100 the next cycle; then ev_valid_o=1, ev_addr_o=2, ev_grp_o=0; pending=0 one cycle after GNT.
- All lanes: ev_i=1111 in one cycle, with the arbiter model returning grants 0001,0010,0100,1000 and asserting arb_grp_rel_i on the ARB cycle after lane 3 -> FIFO outputs addr 0,1,2,3 all with grp 0. A second burst 1111 yields grp 1. arb_en_o pulses every 2 cycles.
- Backpressure: ev_ready_i=0 and 5 distinct events with DEPTH=4 -> exactly 4 pushes; FSM idles with pending=1 on the fifth lane; releasing ready gives 5 outputs in grant order.
- Drop: ev_i[1] pulsed twice while lane 1 is pending and ungranted -> drop_cnt_o=1. Repeat 300 drops with DROP_W=8 -> drop_cnt_o saturates at 255.
- Same-cycle set/clear: ev_i[0] coincides with the GNT cycle clearing lane 0 -> pending[0] stays 1, drop_cnt_o unchanged, lane 0 is requested again.
- Error/reset: arb_gnt_i=0000 in GNT -> gnt_err_o=1, no push, pending unchanged. Asserting reset during ARB -> all outputs 0 immediately; gnt_err_o cleared.
